// File: rtl/tisaradc_pkg.sv
// Shared constants, lane packing helpers and the saturating correction math
// for the time-interleaved SAR ADC lane capture stage.
package tisaradc_pkg;

  localparam int LANES   = 8;
  localparam int BITS    = 9;
  localparam int FRAME_W = LANES * BITS;

  localparam logic signed [BITS:0] SAT_HI = {2'b00, {(BITS-1){1'b1}}};
  localparam logic signed [BITS:0] SAT_LO = {2'b11, {(BITS-1){1'b0}}};

  typedef enum logic [0:0] {
    CAL_IDLE  = 1'b0,
    CAL_ACCUM = 1'b1
  } cal_state_e;

  function automatic logic [BITS-1:0] lane_get(input logic [FRAME_W-1:0] frame, input int lane);
    return frame[lane*BITS +: BITS];
  endfunction

  function automatic logic [FRAME_W-1:0] lane_put(input logic [FRAME_W-1:0] frame, input int lane,
                                                  input logic [BITS-1:0] word);
    logic [FRAME_W-1:0] f;
    f = frame;
    f[lane*BITS +: BITS] = word;
    return f;
  endfunction

  // Subtracting the mid-code from an offset-binary word is an MSB flip.
  function automatic logic [BITS-1:0] ob_to_tc(input logic [BITS-1:0] raw);
    return raw ^ {1'b1, {(BITS-1){1'b0}}};
  endfunction

  function automatic logic signed [BITS:0] lane_sub(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    return $signed({a[BITS-1], a}) - $signed({b[BITS-1], b});
  endfunction

  function automatic logic [BITS-1:0] saturate(input logic signed [BITS:0] c);
    logic [BITS-1:0] r;
    if (c > SAT_HI) begin
      r = SAT_HI[BITS-1:0];
    end else if (c < SAT_LO) begin
      r = SAT_LO[BITS-1:0];
    end else begin
      r = c[BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tisaradc_frame_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra bit so that full and
// empty are distinguishable. A write while full only lands if a pop frees a slot.
module tisaradc_frame_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  // Flags, handshake qualification and the head-entry view.
  always_comb begin
    empty   = (wr_ptr_r == rd_ptr_r);
    full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s   = rd_en && !empty;
    push_s  = wr_en && (!full || pop_s);
    rd_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clock) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/tisaradc_lane_capture.sv
// Capture, offset-correct and buffer 8-lane TI-SAR ADC frames. Defining
// TISARADC_CAL_ACCUM_EN builds the per-lane mean measurement for calibration.
module tisaradc_lane_capture
  import tisaradc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AVG_LOG2   = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [FRAME_W-1:0] adc_data,
  input  logic [FRAME_W-1:0] lane_offset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_data,
  output logic               overflow,
  input  logic               ovf_clear,
  input  logic               cal_start,
  output logic               cal_busy,
  output logic               cal_done,
  output logic [FRAME_W-1:0] cal_mean
);

  logic               v1_r;
  logic [FRAME_W-1:0] raw_r;
  logic               v2_r;
  logic [FRAME_W-1:0] corr_r;
  logic [FRAME_W-1:0] s_frame_s;
  logic [FRAME_W-1:0] corr_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               drop_s;
  logic               overflow_r;

  // Stage 1: frame capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_r  <= 1'b0;
      raw_r <= {FRAME_W{1'b0}};
    end else begin
      v1_r <= in_valid;
      if (in_valid) raw_r <= adc_data;
    end
  end

  // Per-lane two's complement conversion and saturating offset subtraction.
  always_comb begin
    s_frame_s = {FRAME_W{1'b0}};
    corr_s    = {FRAME_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      s_frame_s = lane_put(s_frame_s, i, ob_to_tc(lane_get(raw_r, i)));
    end
    for (int i = 0; i < LANES; i++) begin
      corr_s = lane_put(corr_s, i, saturate(lane_sub(lane_get(s_frame_s, i), lane_get(lane_offset, i))));
    end
  end

  // Stage 2: corrected frame register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v2_r   <= 1'b0;
      corr_r <= {FRAME_W{1'b0}};
    end else begin
      v2_r <= v1_r;
      if (v1_r) corr_r <= corr_s;
    end
  end

  tisaradc_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (v2_r),
    .wr_data (corr_r),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign out_valid = !fifo_empty_s;
  assign drop_s    = v2_r && fifo_full_s && !(out_valid && out_ready);
  assign overflow  = overflow_r;

  // Sticky drop flag; a drop outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clear) begin
      overflow_r <= 1'b0;
    end
  end

`ifdef TISARADC_CAL_ACCUM_EN
  localparam int ACC_W = BITS + AVG_LOG2;

  cal_state_e          cal_state_r;
  cal_state_e          cal_state_nx;
  logic [FRAME_W-1:0]  s2_r;
  logic signed [ACC_W-1:0] acc_r     [LANES];
  logic signed [ACC_W-1:0] acc_sum_s [LANES];
  logic [AVG_LOG2-1:0] cnt_r;
  logic                cal_done_r;
  logic [FRAME_W-1:0]  cal_mean_r;
  logic [FRAME_W-1:0]  mean_s;
  logic                clr_s;
  logic                add_s;
  logic                fin_s;

  // Uncorrected samples travel alongside the corrected frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s2_r <= {FRAME_W{1'b0}};
    end else if (v1_r) begin
      s2_r <= s_frame_s;
    end
  end

  // Running sums; the top BITS bits of a sum are its arithmetic shift by AVG_LOG2.
  always_comb begin
    mean_s = {FRAME_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      acc_sum_s[i] = acc_r[i] + {{AVG_LOG2{s2_r[i*BITS+BITS-1]}}, lane_get(s2_r, i)};
      mean_s = lane_put(mean_s, i, acc_sum_s[i][AVG_LOG2 +: BITS]);
    end
  end

  // Calibration next-state and control.
  always_comb begin
    cal_state_nx = cal_state_r;
    clr_s        = 1'b0;
    add_s        = 1'b0;
    fin_s        = 1'b0;
    case (cal_state_r)
      CAL_IDLE: begin
        if (cal_start) begin
          clr_s        = 1'b1;
          cal_state_nx = CAL_ACCUM;
        end else begin
          cal_state_nx = CAL_IDLE;
        end
      end
      CAL_ACCUM: begin
        if (v2_r) begin
          add_s = 1'b1;
          if (cnt_r == {AVG_LOG2{1'b1}}) begin
            fin_s        = 1'b1;
            cal_state_nx = CAL_IDLE;
          end else begin
            cal_state_nx = CAL_ACCUM;
          end
        end else begin
          cal_state_nx = CAL_ACCUM;
        end
      end
      default: cal_state_nx = CAL_IDLE;
    endcase
  end

  // Calibration state, accumulators and result registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cal_state_r <= CAL_IDLE;
      cnt_r       <= {AVG_LOG2{1'b0}};
      cal_done_r  <= 1'b0;
      cal_mean_r  <= {FRAME_W{1'b0}};
      for (int i = 0; i < LANES; i++) acc_r[i] <= {ACC_W{1'b0}};
    end else begin
      cal_state_r <= cal_state_nx;
      if (clr_s) begin
        cnt_r      <= {AVG_LOG2{1'b0}};
        cal_done_r <= 1'b0;
        for (int i = 0; i < LANES; i++) acc_r[i] <= {ACC_W{1'b0}};
      end else if (add_s) begin
        cnt_r <= cnt_r + {{(AVG_LOG2-1){1'b0}}, 1'b1};
        for (int i = 0; i < LANES; i++) acc_r[i] <= acc_sum_s[i];
        if (fin_s) begin
          cal_done_r <= 1'b1;
          cal_mean_r <= mean_s;
        end
      end
    end
  end

  assign cal_busy = (cal_state_r == CAL_ACCUM);
  assign cal_done = cal_done_r;
  assign cal_mean = cal_mean_r;
`else
  logic cal_unused_s;
  assign cal_unused_s = cal_start & (AVG_LOG2 != 0);
  assign cal_busy     = 1'b0;
  assign cal_done     = 1'b0;
  assign cal_mean     = {FRAME_W{1'b0}};
`endif

endmodule

// File: tb/tb_tisaradc_lane_capture.sv
// Self-checking bench for tisaradc_lane_capture: table vectors, corner
// sequences and a randomized run against a queue-based reference model.
module tb_tisaradc_lane_capture;

`ifdef TISARADC_CAL_ACCUM_EN
  localparam int AVG = 4;
`else
  localparam int AVG = 10;
`endif

  logic        clock = 1'b0;
  logic        reset_n, in_valid, out_ready, ovf_clear, cal_start;
  logic [71:0] adc_data, lane_offset;
  logic        out_valid, overflow, cal_busy, cal_done;
  logic [71:0] out_data, cal_mean;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [71:0] raw;
    logic [71:0] off;
    logic [71:0] exp;
  } vec_t;
  vec_t vt [4];

  typedef struct {
    int          due;
    logic [71:0] f;
  } pend_t;

  tisaradc_lane_capture #(.FIFO_DEPTH(4), .AVG_LOG2(AVG)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .adc_data(adc_data),
    .lane_offset(lane_offset), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow), .ovf_clear(ovf_clear),
    .cal_start(cal_start), .cal_busy(cal_busy), .cal_done(cal_done), .cal_mean(cal_mean)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int l [8];
    logic [71:0] f;
    l = '{a0, a1, a2, a3, a4, a5, a6, a7};
    f = '0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = l[i];
      f[i*9 +: 9] = w[8:0];
    end
    return f;
  endfunction

  // Lane i carries base+i.
  function automatic logic [71:0] seqf(input int base);
    logic [71:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = base + i;
      f[i*9 +: 9] = w[8:0];
    end
    return f;
  endfunction

  // Reference: signed value = raw - 256, minus offset, clamped to [-256, 255].
  function automatic logic [71:0] conv(input logic [71:0] raw, input logic [71:0] off);
    logic [71:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      logic [8:0]  rw, ow;
      logic [31:0] cw;
      int c;
      rw = raw[i*9 +: 9];
      ow = off[i*9 +: 9];
      c  = int'(rw) - 256 - int'($signed(ow));
      if (c > 255) c = 255;
      if (c < -256) c = -256;
      cw = c;
      f[i*9 +: 9] = cw[8:0];
    end
    return f;
  endfunction

  initial begin
    logic [71:0] q [$];
    pend_t       pend [$];
    logic        ovf_m, exp_v, pop, drop;
    logic [95:0] rr;
    int          n;

    reset_n = 1'b0; in_valid = 1'b0; adc_data = '0; lane_offset = '0;
    out_ready = 1'b0; ovf_clear = 1'b0; cal_start = 1'b0;

    vt[0].raw = pk(256, 256, 256, 511, 256, 0, 256, 256);
    vt[0].off = pk(0, 0, 0, -10, 0, 10, 0, 0);
    vt[0].exp = pk(0, 0, 0, 255, 0, -256, 0, 0);
    vt[1].raw = pk(0, 511, 100, 300, 256, 257, 255, 400);
    vt[1].off = pk(0, 0, 0, 0, 0, 0, 0, 0);
    vt[1].exp = pk(-256, 255, -156, 44, 0, 1, -1, 144);
    vt[2].raw = pk(511, 0, 511, 0, 300, 200, 256, 256);
    vt[2].off = pk(-256, 255, 100, -100, 50, -50, -256, 255);
    vt[2].exp = pk(255, -256, 155, -156, -6, -6, 255, -255);
    vt[3].raw = pk(266, 246, 356, 156, 0, 511, 128, 384);
    vt[3].off = pk(10, -10, 100, -100, -1, 1, 0, 0);
    vt[3].exp = pk(0, 0, 0, 0, -255, 254, -128, 128);

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk1("rst_valid", out_valid, 1'b0);
    chk ("rst_data", out_data, '0);
    chk1("rst_ovf", overflow, 1'b0);
    chk1("rst_busy", cal_busy, 1'b0);
    chk1("rst_done", cal_done, 1'b0);
    chk ("rst_mean", cal_mean, '0);
    reset_n = 1'b1;

    // Mid-code frame and latency.
    out_ready = 1'b1; in_valid = 1'b1; adc_data = seqf(256) & '0 | pk(256, 256, 256, 256, 256, 256, 256, 256);
    tick(1); in_valid = 1'b0;
    chk1("lat_edge_k", out_valid, 1'b0);
    tick(1); chk1("lat_edge_k1", out_valid, 1'b0);
    tick(1); chk1("lat_edge_k2", out_valid, 1'b1);
    chk ("mid_code", out_data, '0);
    tick(1); chk1("lat_popped", out_valid, 1'b0);
    chk ("empty_data", out_data, '0);

    // Table of single-frame correction vectors.
    for (int v = 0; v < 4; v++) begin
      lane_offset = vt[v].off; adc_data = vt[v].raw; in_valid = 1'b1;
      tick(1); in_valid = 1'b0;
      tick(2);
      chk1($sformatf("vec%0d_valid", v), out_valid, 1'b1);
      chk ($sformatf("vec%0d_data", v), out_data, vt[v].exp);
      tick(1);
    end

    // Back-pressure: 6 frames into a 4-deep FIFO.
    lane_offset = '0; out_ready = 1'b0;
    for (int f = 0; f < 6; f++) begin
      in_valid = 1'b1; adc_data = seqf(256 + 10*f); tick(1);
    end
    in_valid = 1'b0; tick(3);
    chk1("bp_ovf_set", overflow, 1'b1);
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("bp_pop%0d", f), out_data, seqf(10*f));
      tick(1);
    end
    chk1("bp_empty", out_valid, 1'b0);
    out_ready = 1'b0; ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
    chk1("ovf_cleared", overflow, 1'b0);

    // Write and read in the same cycle while full.
    for (int f = 0; f < 4; f++) begin
      in_valid = 1'b1; adc_data = seqf(256 + 8*f); tick(1);
    end
    in_valid = 1'b0; tick(2);
    in_valid = 1'b1; adc_data = seqf(256 + 32); tick(1);
    in_valid = 1'b0; tick(1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    chk1("full_rw_no_ovf", overflow, 1'b0);
    out_ready = 1'b1;
    for (int f = 1; f < 5; f++) begin
      chk($sformatf("full_rw_pop%0d", f), out_data, seqf(8*f));
      tick(1);
    end
    chk1("full_rw_empty", out_valid, 1'b0);
    out_ready = 1'b0;

    // Drop coinciding with ovf_clear.
    for (int f = 0; f < 4; f++) begin
      in_valid = 1'b1; adc_data = seqf(256 + 8*f); tick(1);
    end
    in_valid = 1'b0; tick(2);
    in_valid = 1'b1; adc_data = seqf(256 + 32); tick(1);
    in_valid = 1'b0; tick(1);
    chk1("pre_drop_ovf", overflow, 1'b0);
    ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
    chk1("drop_beats_clear", overflow, 1'b1);
    chk ("drop_head_kept", out_data, seqf(0));
    out_ready = 1'b1; tick(4);
    chk1("drop_drained", out_valid, 1'b0);

    // Calibration.
`ifdef TISARADC_CAL_ACCUM_EN
    cal_start = 1'b1; tick(1); cal_start = 1'b0;
    chk1("cal_busy_set", cal_busy, 1'b1);
    chk1("cal_done_clr", cal_done, 1'b0);
    for (int f = 0; f < 16; f++) begin
      if (f == 8) chk1("cal_mid_done", cal_done, 1'b0);
      in_valid = 1'b1; adc_data = seqf(253); cal_start = (f == 5); tick(1);
    end
    in_valid = 1'b0; cal_start = 1'b0;
    tick(1); chk1("cal_not_early", cal_done, 1'b0);
    tick(1);
    chk1("cal_done_set", cal_done, 1'b1);
    chk1("cal_busy_clr", cal_busy, 1'b0);
    chk ("cal_mean", cal_mean, seqf(-3));
`else
    cal_start = 1'b1; in_valid = 1'b1; adc_data = seqf(253); tick(1);
    cal_start = 1'b0; in_valid = 1'b0; tick(3);
    chk1("nocal_busy", cal_busy, 1'b0);
    chk1("nocal_done", cal_done, 1'b0);
    chk ("nocal_mean", cal_mean, '0);
`endif
    tick(3);

    // Reset with frames buffered and calibration running.
    out_ready = 1'b0;
`ifdef TISARADC_CAL_ACCUM_EN
    cal_start = 1'b1; tick(1); cal_start = 1'b0;
`endif
    for (int f = 0; f < 2; f++) begin
      in_valid = 1'b1; adc_data = seqf(256 + f); tick(1);
    end
    in_valid = 1'b0; tick(2);
    chk1("pre_rst_valid", out_valid, 1'b1);
    chk1("pre_rst_ovf", overflow, 1'b1);
`ifdef TISARADC_CAL_ACCUM_EN
    chk1("pre_rst_busy", cal_busy, 1'b1);
`endif
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_ovf", overflow, 1'b0);
    chk1("mid_rst_busy", cal_busy, 1'b0);
    chk1("mid_rst_done", cal_done, 1'b0);
    chk ("mid_rst_data", out_data, '0);

    // Randomized traffic against the queue model.
    rr = {$urandom(), $urandom(), $urandom()};
    lane_offset = rr[71:0];
    ovf_m = 1'b0; n = 0;
    for (int c = 0; c < 600; c++) begin
      exp_v = (q.size() != 0);
      chk1("rnd_valid", out_valid, exp_v);
      chk ("rnd_data", out_data, exp_v ? q[0] : 72'h0);
      chk1("rnd_ovf", overflow, ovf_m);
      rr = {$urandom(), $urandom(), $urandom()};
      adc_data  = rr[71:0];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 99) < (((c / 100) % 2 == 1) ? 85 : 25));
      ovf_clear = ($urandom_range(0, 15) == 0);
      pop  = exp_v && out_ready;
      drop = 1'b0;
      if (pop) void'(q.pop_front());
      if (pend.size() != 0 && pend[0].due == n) begin
        pend_t p;
        p = pend.pop_front();
        if (q.size() < 4) q.push_back(p.f);
        else drop = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
      else if (ovf_clear) ovf_m = 1'b0;
      if (in_valid) pend.push_back('{n + 2, conv(adc_data, lane_offset)});
      n++;
      tick(1);
    end
    in_valid = 1'b0; ovf_clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
